// File: rtl/seven_seg.sv
// Four-digit multiplexed common-anode 7-segment driver for the Simon score display.
// Shows the score in decimal with leading-zero blanking, or "----" before a game starts.
module seven_seg #(
  parameter int DIGIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] score,
  input  logic       game_started,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

  // Segment patterns, gfedcba, active-low
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_wrap;
  logic [6:0]    w_hund;
  logic [6:0]    w_tens;
  logic [6:0]    w_ones;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;

  function automatic logic [6:0] digit_to_seg(input logic [6:0] d);
    logic [6:0] code;
    code = SEG_BLANK;
    case (d)
      7'd0:    code = 7'b1000000;
      7'd1:    code = 7'b1111001;
      7'd2:    code = 7'b0100100;
      7'd3:    code = 7'b0110000;
      7'd4:    code = 7'b0011001;
      7'd5:    code = 7'b0010010;
      7'd6:    code = 7'b0000010;
      7'd7:    code = 7'b1111000;
      7'd8:    code = 7'b0000000;
      7'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  assign w_wrap = (r_cnt == CNT_LAST);

  // Constant division on a 7-bit operand stays small; results are 0..9 by construction.
  always_comb begin
    w_hund = score / 7'd100;
    w_tens = (score % 7'd100) / 7'd10;
    w_ones = score % 7'd10;
  end

  always_comb begin
    w_seg_next = SEG_BLANK;
    w_an_next  = ~(4'b0001 << r_idx);
    if (!game_started) begin
      w_seg_next = SEG_DASH;
    end else begin
      case (r_idx)
        2'd0: w_seg_next = digit_to_seg(w_ones);
        2'd1: w_seg_next = ((w_hund == 7'd0) && (w_tens == 7'd0)) ? SEG_BLANK
                                                                   : digit_to_seg(w_tens);
        2'd2: w_seg_next = (w_hund == 7'd0) ? SEG_BLANK : digit_to_seg(w_hund);
        default: w_seg_next = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Outputs lag the index by one edge so anode and cathodes always switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seven_seg.sv
// Bench for seven_seg with a short scan period; expected anode/segment pairs are
// queued before each edge and compared on the following falling edge.
module tb_seven_seg;

  localparam int DC = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] score;
  logic       game_started;
  logic [6:0] seg;
  logic [3:0] an;

  int total;
  int bad;
  int k;

  logic [10:0] exp_q[$];
  logic [6:0]  seg_tab[10];

  seven_seg #(.DIGIT_CYCLES(DC)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .score        (score),
    .game_started (game_started),
    .seg          (seg),
    .an           (an)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (k=%0d score=%0d gs=%0b)",
               tag, obs, exp, k, score, game_started);
    end
  endtask

  // Expected {an, seg} after edge number kk since reset release.
  function automatic logic [10:0] model(input int kk, input logic [6:0] s, input logic g);
    int idx;
    int h;
    int t;
    int o;
    logic [3:0] a;
    logic [6:0] sg;
    idx = (kk / DC) % 4;
    a   = 4'b1111;
    a[idx] = 1'b0;
    h = int'(s) / 100;
    t = (int'(s) % 100) / 10;
    o = int'(s) % 10;
    sg = 7'b1111111;
    if (!g) sg = 7'b0111111;
    else if (idx == 0) sg = seg_tab[o];
    else if (idx == 1 && (h != 0 || t != 0)) sg = seg_tab[t];
    else if (idx == 2 && h != 0) sg = seg_tab[h];
    return {a, sg};
  endfunction

  // One clock: queue the expectation, take the edge, compare on the falling edge.
  task automatic cycle(input string tag);
    logic [10:0] e;
    exp_q.push_back(model(k, score, game_started));
    @(posedge clk);
    k++;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 11'h0, 11'h7ff);
    end else begin
      e = exp_q.pop_front();
      check(tag, {an, seg}, e);
    end
  endtask

  task automatic scan(input string tag, input logic g, input logic [6:0] s);
    game_started = g;
    score        = s;
    for (int i = 0; i < 4 * DC; i++) cycle(tag);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    total = 0;
    bad   = 0;
    k     = 0;
    rst_n = 1'b0;
    score = 7'd0;
    game_started = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_hold", {an, seg}, 11'h7ff);

    // release between edges; first edge must light digit 0
    rst_n = 1'b1;
    k = 0;
    scan("idle_55", 1'b0, 7'd55);
    scan("score_0", 1'b1, 7'd0);
    scan("score_7", 1'b1, 7'd7);
    scan("score_42", 1'b1, 7'd42);
    scan("score_105", 1'b1, 7'd105);
    scan("score_127", 1'b1, 7'd127);
    scan("score_100", 1'b1, 7'd100);
    scan("score_9", 1'b1, 7'd9);
    scan("score_10", 1'b1, 7'd10);

    // input changes mid-scan must show up on the next digit slot
    for (int i = 0; i < 40; i++) begin
      score        = 7'($urandom_range(0, 127));
      game_started = ($urandom_range(0, 7) != 0);
      for (int j = 0; j < $urandom_range(1, 6); j++) cycle("rand");
    end

    // advance into the index-2 slot, then reset asynchronously mid-slot
    game_started = 1'b1;
    score = 7'd123;
    while (!(((k - 1) / DC) % 4 == 2 && (k - 1) % DC == 1)) cycle("to_idx2");
    check("pre_rst_an", {an, 7'h0}, {4'b1011, 7'h0});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {an, seg}, 11'h7ff);
    repeat (2) @(negedge clk);
    check("rst_held", {an, seg}, 11'h7ff);
    rst_n = 1'b1;
    k = 0;
    cycle("resume_first");
    check("resume_an", {an, 7'h0}, {4'b1110, 7'h0});
    for (int i = 0; i < 4 * DC; i++) cycle("resume");

    check("queue_empty", 11'(exp_q.size()), 11'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
